// File: rtl/stdp_pair_timer.sv
// stdp_pair_timer: per-synapse pre/post spike timer feeding the STDP stage.
// Ports: clk, rst (async, active-high), step, pre_spike, post_spike, ack ->
//        t_change[N-1:0] (sign-magnitude fixed point), apply, dropped[7:0],
//        fifo_count[$clog2(DEPTH):0].
module stdp_pair_timer #(
    parameter int N      = 32,
    parameter int Q      = 16,
    parameter int CW     = 12,
    parameter int WINDOW = 100,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step,
    input  logic                   pre_spike,
    input  logic                   post_spike,
    input  logic                   ack,
    output logic [N-1:0]           t_change,
    output logic                   apply,
    output logic [7:0]             dropped,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] WIN = CW'(WINDOW);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    // ---------------- spike timing state ----------------
    logic [CW-1:0] since_pre_q;
    logic [CW-1:0] since_post_q;
    logic          pre_seen_q;
    logic          post_seen_q;

    logic [CW-1:0] inc_pre;
    logic [CW-1:0] inc_post;

    // Saturate at WINDOW; compare against WINDOW-1 so c+1 can never wrap.
    always_comb begin
        inc_pre  = (since_pre_q >= WIN - CW'(1)) ? WIN : since_pre_q + CW'(1);
        inc_post = (since_post_q >= WIN - CW'(1)) ? WIN : since_post_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            since_pre_q  <= WIN;
            since_post_q <= WIN;
            pre_seen_q   <= 1'b0;
            post_seen_q  <= 1'b0;
        end else if (step) begin
            since_pre_q  <= pre_spike ? '0 : inc_pre;
            since_post_q <= post_spike ? '0 : inc_post;
            pre_seen_q   <= pre_seen_q | pre_spike;
            post_seen_q  <= post_seen_q | post_spike;
        end
    end

    // ---------------- pairing and encoding ----------------
    logic          causal;
    logic          acausal;
    logic          ev_valid;
    logic [CW-1:0] ev_mag;
    logic [N-2:0]  mag_ext;
    logic [N-1:0]  ev_data;

    always_comb begin
        causal   = step & post_spike & ~pre_spike & pre_seen_q
                   & (inc_pre < WIN);
        acausal  = step & pre_spike & ~post_spike & post_seen_q
                   & (inc_post < WIN);
        ev_valid = causal | acausal;
        ev_mag   = causal ? inc_pre : inc_post;
        mag_ext  = (N - 1)'(ev_mag) << Q;
        ev_data  = {acausal, mag_ext};
    end

    // ---------------- event FIFO ----------------
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          pop;
    logic          push_ok;
    logic          fifo_empty;

    assign fifo_empty = (count_q == '0);

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push_ok = ev_valid & ((count_q != FULL) | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= ev_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            dropped <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, push_ok}
                       - {{AW{1'b0}}, pop};
            if (ev_valid && !push_ok && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    assign fifo_count = count_q;

    // ---------------- output register FSM ----------------
    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ack) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_change <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                t_change <= mem[rd_q];
            end
        end
    end

    assign apply = (state_q == ISSUE);

endmodule

// File: tb/tb_stdp_pair_timer.sv
// tb_stdp_pair_timer: directed self-checking bench for stdp_pair_timer.
// Drives step/spike/ack vectors and checks apply, t_change, fifo_count, dropped.
module tb_stdp_pair_timer;

    logic        clk;
    logic        rst;
    logic        step;
    logic        pre_spike;
    logic        post_spike;
    logic        ack;
    logic [31:0] t_change;
    logic        apply;
    logic [7:0]  dropped;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    stdp_pair_timer #(
        .N(32), .Q(16), .CW(12), .WINDOW(100), .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step(step),
        .pre_spike(pre_spike),
        .post_spike(post_spike),
        .ack(ack),
        .t_change(t_change),
        .apply(apply),
        .dropped(dropped),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic pr, input logic po);
        step       = s;
        pre_spike  = pr;
        post_spike = po;
        @(posedge clk);
        #1;
        step       = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        step       = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        ack        = 1'b0;
        #2;
        chk("rst_apply", 32'(apply), 32'd0);
        chk("rst_t", t_change, 32'd0);
        chk("rst_fifo", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // causal pair, ack tied high
        ack = 1'b1;
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("causal_pre_apply", 32'(apply), 32'd0);
        chk("causal_fifo", 32'(fifo_count), 32'd1);
        cyc(0, 0, 0);
        chk("causal_apply", 32'(apply), 32'd1);
        chk("causal_t", t_change, 32'h0003_0000);
        chk("causal_fifo0", 32'(fifo_count), 32'd0);
        cyc(0, 0, 0);
        chk("causal_fall", 32'(apply), 32'd0);

        // acausal pair, ack pulsed late
        ack = 1'b0;
        do_reset();
        cyc(1, 0, 1);
        repeat (4) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("acausal_apply", 32'(apply), 32'd1);
        chk("acausal_t", t_change, 32'h8005_0000);
        repeat (3) cyc(0, 0, 0);
        chk("acausal_hold_apply", 32'(apply), 32'd1);
        chk("acausal_hold_t", t_change, 32'h8005_0000);
        ack = 1'b1;
        cyc(0, 0, 0);
        ack = 1'b0;
        chk("acausal_fall", 32'(apply), 32'd0);

        // simultaneous spikes: no event
        ack = 1'b1;
        do_reset();
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        chk("simul_apply", 32'(apply), 32'd0);
        chk("simul_fifo", 32'(fifo_count), 32'd0);

        // dt = WINDOW: no event
        do_reset();
        cyc(1, 1, 0);
        repeat (99) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("win_fifo", 32'(fifo_count), 32'd0);
        cyc(0, 0, 0);
        chk("win_apply", 32'(apply), 32'd0);

        // dt = WINDOW-1: event 99
        do_reset();
        cyc(1, 1, 0);
        repeat (98) cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        chk("win1_apply", 32'(apply), 32'd1);
        chk("win1_t", t_change, 32'h0063_0000);

        // overflow: 6 events, ack low
        ack = 1'b0;
        do_reset();
        cyc(1, 1, 0);
        repeat (6) cyc(1, 0, 1);
        chk("ovf_apply", 32'(apply), 32'd1);
        chk("ovf_t1", t_change, 32'h0001_0000);
        chk("ovf_fifo", 32'(fifo_count), 32'd4);
        chk("ovf_drop", 32'(dropped), 32'd1);
        ack = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 0, 0);
            chk("ovf_drain_apply", 32'(apply), 32'd1);
            chk("ovf_drain_t", t_change, 32'(i) << 16);
            chk("ovf_drain_fifo", 32'(fifo_count), 32'(5 - i));
        end
        cyc(0, 0, 0);
        chk("ovf_end_apply", 32'(apply), 32'd0);
        chk("ovf_end_drop", 32'(dropped), 32'd1);

        // reset mid-operation
        ack = 1'b0;
        do_reset();
        cyc(1, 1, 0);
        repeat (4) cyc(1, 0, 1);
        chk("mid_fifo", 32'(fifo_count), 32'd3);
        chk("mid_apply", 32'(apply), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_apply", 32'(apply), 32'd0);
        chk("mid_rst_fifo", 32'(fifo_count), 32'd0);
        chk("mid_rst_drop", 32'(dropped), 32'd0);
        chk("mid_rst_t", t_change, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack = 1'b1;
        cyc(1, 0, 1);
        chk("post_rst_fifo", 32'(fifo_count), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("post_rst_apply", 32'(apply), 32'd0);

        // no step: spikes ignored, counters hold
        do_reset();
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        chk("nostep_apply", 32'(apply), 32'd0);
        chk("nostep_fifo", 32'(fifo_count), 32'd0);
        do_reset();
        cyc(1, 1, 0);
        repeat (5) cyc(0, 0, 1);
        chk("hold_fifo", 32'(fifo_count), 32'd0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        chk("hold_apply", 32'(apply), 32'd1);
        chk("hold_t", t_change, 32'h0002_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
